debug_dmi_arbiter: RTL
======================

# debug_dmi_arbiter

Parametrised N-channel arbiter for the debug request/response port of the Rocket top level. It lets NUM_CH independent debug masters share the single `io_debug_req_*`/`io_debug_resp_*` port, for example a JTAG DTM, a PS-side mailbox and per-partition control agents. The arbiter uses round-robin grant with one transaction outstanding and routes each response back to the channel that issued it. It sits between the debug masters and the core wrapper, in the uncore clock domain.

## Interface
Parameters:
- NUM_CH, 2: number of upstream debug channels, 2 to 8.
- ADDR_W, 5: debug address width.
- DATA_W, 34: debug data width.
- TIMEOUT_CYCLES, 1024: response watchdog limit. Used only when the timeout feature is compiled in.

Ports:
- uncoreclk, in, 1: the single clock.
- uncorerst, in, 1: reset, asynchronous, active-high.
- ch_req_valid, in, NUM_CH: per-channel request valid.
- ch_req_ready, out, NUM_CH: per-channel request ready.
- ch_req_addr, in, NUM_CH*ADDR_W: channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_req_op, in, NUM_CH*2: per-channel op.
- ch_req_data, in, NUM_CH*DATA_W: per-channel write data.
- ch_resp_valid, out, NUM_CH: per-channel response valid.
- ch_resp_ready, in, NUM_CH: per-channel response ready.
- ch_resp_resp, out, 2: response code, shared by all channels; qualified by ch_resp_valid.
- ch_resp_data, out, DATA_W: response data, shared; qualified by ch_resp_valid.
- io_debug_req_valid, out, 1: downstream request valid.
- io_debug_req_ready, in, 1: downstream request ready.
- io_debug_req_bits_addr, out, ADDR_W: downstream address.
- io_debug_req_bits_op, out, 2: downstream op.
- io_debug_req_bits_data, out, DATA_W: downstream write data.
- io_debug_resp_valid, in, 1: downstream response valid.
- io_debug_resp_ready, out, 1: downstream response ready.
- io_debug_resp_bits_resp, in, 2: downstream response code.
- io_debug_resp_bits_data, in, DATA_W: downstream response data.
- busy, out, 1: high whenever the FSM is not in IDLE.
- grant_id, out, $clog2(NUM_CH): index of the channel currently owning the port.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first valid channel scanning from rr_ptr upward, wrapping at NUM_CH.
  - ch_req_ready is high for the picked channel only, combinationally.
  - On handshake: latch addr/op/data and grant_id, set rr_ptr = grant+1 mod NUM_CH, go to ISSUE.
- ISSUE:
  - io_debug_req_valid = 1 with the latched fields, held stable until io_debug_req_ready.
  - Then go to WAIT.
- WAIT:
  - io_debug_resp_ready = 1.
  - On io_debug_resp_valid: capture resp/data, go to RESP.
- RESP:
  - ch_resp_valid[grant_id] = 1; all other channels read 0.
  - On ch_resp_ready[grant_id]: go to IDLE.
- Responses on any channel that is not granted are never asserted.
- Other channels' requests are held off (ready = 0) in every state except IDLE.
- Reset values:
  - All outputs 0, including ch_req_ready and io_debug_resp_ready.
  - rr_ptr = 0, state = IDLE.
- Reset mid-transaction: any in-flight transaction is discarded. The downstream target is reset together with this block through the shared uncorerst.

## Timing
- Upstream accept in cycle N: io_debug_req_valid is high from N+1.
- Downstream response handshake in cycle M: ch_resp_valid is high from M+1.
- Minimum round trip is 4 cycles with ready/valid asserted immediately at each step.
- No combinational path from any ch_* input to any io_debug_* output, or from io_debug_* inputs to ch_* outputs. The only exception is the IDLE grant logic driving ch_req_ready.
- Simultaneous requests from all channels: strict rotation, so each channel is served once per NUM_CH transactions.
- rr_ptr wraps from NUM_CH-1 to 0.

## Configuration
- DEBUG_DMI_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. When it reaches TIMEOUT_CYCLES, capture resp = 2'b10 and data = 0, go to RESP, and set the stale flag.
  - While stale = 1: io_debug_resp_ready = 1 in all states, and IDLE grants nothing.
  - The next io_debug_resp handshake clears stale and its content is dropped.
  - The counter is cleared on entry to WAIT.
- Undefined: no counter and no stale flag; WAIT persists indefinitely.

## Structure
- Shared package holds:
  - the debug op encodings (read = 1, write = 2);
  - the response encodings (success = 0, failed = 2);
  - the FSM state typedef;
  - the ADDR_W/DATA_W defaults shared with the core wrapper.
- One sub-module, `rr_picker`:
  - Parameter: NUM_CH.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant and its index.
  - Purely combinational.

## Test plan
- Single channel 0 read, addr 5'h11, op 1; target returns data 34'h2_DEAD_BEEF, resp 0 -> only ch0 sees the response with those values; 4 cycles total with zero stalls.
- All NUM_CH=4 channels request continuously, starting from reset -> grant order 0,1,2,3,0; no channel is served twice before every other channel has been served once.
- Downstream ready withheld 7 cycles in ISSUE -> addr/op/data stable every cycle; no upstream ready during that time.
- ch_resp_ready low 5 cycles in RESP -> response held stable; the pending ch2 request is not accepted until the cycle after the RESP handshake.
- uncorerst pulsed during WAIT -> all outputs 0 asynchronously, rr_ptr = 0; the next request completes normally.
- With DEBUG_DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no downstream response -> requester gets resp 2'b10, data 0, on cycle 17 of WAIT. The late response arriving 10 cycles afterwards is drained and dropped, and the queued ch1 request is accepted only after the drain.

Source files
------------

// File: rtl/debug_dmi_arbiter_pkg.sv
// Shared debug-port encodings, FSM state type and width defaults for the
// debug DMI arbiter and the core wrapper.
package debug_dmi_arbiter_pkg;

  localparam int DMI_ADDR_W = 5;
  localparam int DMI_DATA_W = 34;

  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/debug_dmi_arbiter_rr_picker.sv
// Round-robin picker: grants the first requester at or above rr_ptr,
// wrapping at NUM_CH. Purely combinational.
module rr_picker #(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  // Distance from the pointer going upward around the ring.
  function automatic int ring_dist(input int ch, input int ptr);
    return (ch >= ptr) ? (ch - ptr) : (ch - ptr + NUM_CH);
  endfunction

  int best_dist;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    best_dist = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i] && (ring_dist(i, int'(rr_ptr)) < best_dist)) begin
        best_dist = ring_dist(i, int'(rr_ptr));
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/debug_dmi_arbiter.sv
// N-channel round-robin arbiter for the Rocket debug req/resp port, one
// transaction outstanding. Optional response watchdog: DEBUG_DMI_ARB_TIMEOUT_EN.
module debug_dmi_arbiter
  import debug_dmi_arbiter_pkg::*;
#(
  parameter  int NUM_CH         = 2,
  parameter  int ADDR_W         = DMI_ADDR_W,
  parameter  int DATA_W         = DMI_DATA_W,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = $clog2(NUM_CH)
) (
  input  logic                     uncoreclk,
  input  logic                     uncorerst,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH*2-1:0]      ch_req_op,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_data,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  input  logic [NUM_CH-1:0]        ch_resp_ready,
  output logic [1:0]               ch_resp_resp,
  output logic [DATA_W-1:0]        ch_resp_data,
  output logic                     io_debug_req_valid,
  input  logic                     io_debug_req_ready,
  output logic [ADDR_W-1:0]        io_debug_req_bits_addr,
  output logic [1:0]               io_debug_req_bits_op,
  output logic [DATA_W-1:0]        io_debug_req_bits_data,
  input  logic                     io_debug_resp_valid,
  output logic                     io_debug_resp_ready,
  input  logic [1:0]               io_debug_resp_bits_resp,
  input  logic [DATA_W-1:0]        io_debug_resp_bits_data,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  arb_state_e        state, state_nxt;
  logic [NUM_CH-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx, grant_q, rr_ptr;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [1:0]        op_q, sel_op, resp_code_q;
  logic [DATA_W-1:0] data_q, sel_data, resp_data_q;
  logic              req_hs, up_resp_hs, dn_resp_hs;
  logic              stale, timeout_hit;

  rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req       (ch_req_valid & {NUM_CH{~stale}}),
    .rr_ptr    (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx)
  );

  assign req_hs     = |(ch_req_valid & ch_req_ready);
  assign up_resp_hs = |(ch_resp_valid & ch_resp_ready);
  assign dn_resp_hs = io_debug_resp_valid & io_debug_resp_ready;

`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && !io_debug_resp_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stale marks a response still owed by the target after a timeout; it must
  // be drained before anyone else may use the port.
  always_ff @(posedge uncoreclk or posedge uncorerst) begin
    if (uncorerst) begin
      wait_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      if (state == ST_ISSUE)
        wait_cnt <= '0;
      else if (state == ST_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        stale <= 1'b1;
      else if (stale && dn_resp_hs)
        stale <= 1'b0;
    end
  end
`else
  assign stale       = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    sel_addr = '0;
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_onehot[i]) begin
        sel_addr = ch_req_addr[i*ADDR_W +: ADDR_W];
        sel_op   = ch_req_op[i*2 +: 2];
        sel_data = ch_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge uncoreclk or posedge uncorerst) begin
    if (uncorerst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_hs)                     state_nxt = ST_ISSUE;
      ST_ISSUE: if (io_debug_req_ready)         state_nxt = ST_WAIT;
      ST_WAIT:  if (dn_resp_hs || timeout_hit)  state_nxt = ST_RESP;
      ST_RESP:  if (up_resp_hs)                 state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  // Upstream ready is gated by reset so every output reads 0 while it is held.
  always_comb begin
    ch_req_ready        = '0;
    ch_resp_valid       = '0;
    io_debug_req_valid  = 1'b0;
    io_debug_resp_ready = stale;
    busy                = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (!uncorerst) ch_req_ready = pick_onehot;
      ST_ISSUE: io_debug_req_valid = 1'b1;
      ST_WAIT:  io_debug_resp_ready = 1'b1;
      ST_RESP:
        for (int i = 0; i < NUM_CH; i++)
          ch_resp_valid[i] = (grant_q == IDX_W'(i));
      default: ;
    endcase
  end

  always_ff @(posedge uncoreclk or posedge uncorerst) begin
    if (uncorerst) begin
      addr_q      <= '0;
      op_q        <= '0;
      data_q      <= '0;
      grant_q     <= '0;
      rr_ptr      <= '0;
      resp_code_q <= '0;
      resp_data_q <= '0;
    end else begin
      if ((state == ST_IDLE) && req_hs) begin
        addr_q  <= sel_addr;
        op_q    <= sel_op;
        data_q  <= sel_data;
        grant_q <= pick_idx;
        rr_ptr  <= (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == ST_WAIT) begin
        if (dn_resp_hs) begin
          resp_code_q <= io_debug_resp_bits_resp;
          resp_data_q <= io_debug_resp_bits_data;
        end else if (timeout_hit) begin
          resp_code_q <= DMI_RESP_FAILED;
          resp_data_q <= '0;
        end
      end
    end
  end

  assign io_debug_req_bits_addr = addr_q;
  assign io_debug_req_bits_op   = op_q;
  assign io_debug_req_bits_data = data_q;
  assign ch_resp_resp           = resp_code_q;
  assign ch_resp_data           = resp_data_q;
  assign grant_id               = grant_q;

endmodule
